// File: rtl/kuznechik_ls_core.sv
// Kuznechik (GOST R 34.12-2015) L transform (16 serial R steps, one per clock)
// and the combinational pi S layer across all 16 bytes.
module kuznechik_ls_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] input_word,
    output logic [127:0] output_word,
    output logic         finish_convertion,
    input  logic [127:0] s_input_bytes,
    output logic [127:0] s_output_bytes
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // l coefficients indexed by byte position: LCOEF[i] multiplies a_i
    localparam logic [7:0] LCOEF [16] = '{
        8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
        8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
    };

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Multiply by x modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'hC3 : 8'h00);
    endfunction

    // Constant multipliers collapse to XOR trees once c is a literal
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int b = 0; b < 8; b++) begin
            if (c[b]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    function automatic logic [127:0] r_step(input logic [127:0] w);
        logic [7:0] l;
        l = 8'h00;
        for (int i = 0; i < 16; i++)
            l = l ^ gf_mul(w[8*i +: 8], LCOEF[i]);
        return {l, w[127:8]};
    endfunction

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] work;
    logic [127:0] r_next;

    assign r_next = r_step(work);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            work              <= '0;
            output_word       <= '0;
            finish_convertion <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        work  <= input_word;
                        cnt   <= 4'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Requester withdrawing mid-run abandons the result silently
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        work <= r_next;
                        cnt  <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            output_word       <= r_next;
                            finish_convertion <= 1'b1;
                            state             <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        finish_convertion <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        assign s_output_bytes[8*k +: 8] = PI[s_input_bytes[8*k +: 8]];
    end

endmodule

// File: tb/tb_kuznechik_ls_core.sv
// Scoreboard bench for kuznechik_ls_core: L runs checked by a monitor against a
// byte-array reference model, S layer checked against a pi lookup.
module tb_kuznechik_ls_core;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [127:0] input_word;
    logic [127:0] output_word;
    logic         finish_convertion;
    logic [127:0] s_input_bytes;
    logic [127:0] s_output_bytes;

    kuznechik_ls_core dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .input_word        (input_word),
        .output_word       (output_word),
        .finish_convertion (finish_convertion),
        .s_input_bytes     (s_input_bytes),
        .s_output_bytes    (s_output_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] last_out;

    localparam logic [7:0] PI_REF [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Coefficients in the order a15 .. a0
    localparam int COEF [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

    // Schoolbook carry-less product followed by polynomial long division by 0x1C3
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--)
            if (p[k]) p = p ^ (16'h1C3 << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] l_ref(input logic [127:0] x, input int rounds);
        logic [7:0]   a [16];
        logic [7:0]   l;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = x[8*i +: 8];
        for (int n = 0; n < rounds; n++) begin
            l = 8'h00;
            for (int j = 0; j < 16; j++) l = l ^ gmul(a[15 - j], 8'(COEF[j]));
            for (int i = 0; i < 15; i++) a[i] = a[i + 1];
            a[15] = l;
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    function automatic logic [127:0] s_ref(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = PI_REF[x[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic fin_q;
        exp_t e;
        fin_q = 1'b0;
        forever begin
            @(negedge clk);
            if (finish_convertion === 1'b1 && !fin_q) begin
                if (q.size() == 0) begin
                    check("unexpected_finish", {127'b0, finish_convertion}, 128'h0);
                end else begin
                    e = q.pop_front();
                    check("l_result", output_word, e.data);
                    check("l_latency", 128'(cyc), 128'(e.due));
                end
            end
            fin_q = (finish_convertion === 1'b1);
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            check({nm, "_timeout"}, 128'(q.size()), 128'h0);
            q.delete();
        end
    endtask

    task automatic run_l(input logic [127:0] w, input logic [127:0] expv, input bit probe);
        @(negedge clk);
        input_word = w;
        enable     = 1'b1;
        q.push_back('{expv, cyc + 17});
        if (probe) begin
            @(posedge clk);
            @(posedge clk);
            #1 check("work_after_one_r", dut.work, l_ref(w, 1));
        end
        wait_done("run");
        input_word = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check("hold_fin", {127'b0, finish_convertion}, 128'h1);
        check("hold_out", output_word, expv);
        enable = 1'b0;
        @(negedge clk);
        check("drop_fin", {127'b0, finish_convertion}, 128'h0);
        check("drop_out", output_word, expv);
        last_out = expv;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] w;
        reset         = 1'b1;
        enable        = 1'b0;
        input_word    = '0;
        s_input_bytes = '0;
        last_out      = '0;
        fork
            monitor();
        join_none
        #3;
        check("reset_out", output_word, 128'h0);
        check("reset_fin", {127'b0, finish_convertion}, 128'h0);
        check("s_zero", s_output_bytes, {16{8'hFC}});
        s_input_bytes = 128'hffeeddccbbaa99881122334455667700;
        #1 check("s_vector", s_output_bytes, 128'hb66cd8887d38e8d77765aeea0c9a7efc);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_l(128'h1, 128'h6ea276726c487ab85d27bd10dd849401, 1'b0);
        run_l(128'h64a59400000000000000000000000000, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b0);
        run_l(128'h100, l_ref(128'h100, 16), 1'b1);
        check("probe_const", l_ref(128'h100, 1), 128'h94000000000000000000000000000001);

        // Abort after eight R steps; no result may appear
        @(negedge clk);
        input_word = {$urandom, $urandom, $urandom, $urandom};
        enable     = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_fin", {127'b0, finish_convertion}, 128'h0);
        check("abort_out", output_word, last_out);
        run_l(128'h8, 128'hf6593616e6055689adfba18027aa2a08, 1'b0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        input_word = {$urandom, $urandom, $urandom, $urandom};
        enable     = 1'b1;
        q.push_back('{128'h0, 0});
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_out", output_word, 128'h0);
        check("midrun_reset_fin", {127'b0, finish_convertion}, 128'h0);
        q.delete(q.size() - 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        last_out = '0;

        for (int n = 0; n < 6; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            run_l(w, l_ref(w, 16), 1'b0);
        end

        for (int n = 0; n < 20; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            s_input_bytes = w;
            #1 check("s_random", s_output_bytes, s_ref(w));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 128'(q.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
